wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous active-low reset, sampled on clk rising edge.
- stall_i  input  1  hold MEM/WB latch and block commit.
- flush_i  input  1  kill the instruction entering MEM/WB.
- write_reg_en_i  input  1  write-back valid from MEM stage.
- write_reg_addr_i  input  5  destination register from MEM stage.
- write_reg_data_i  input  32  write-back data from MEM stage.
- read1_en_i  input  1  read port 1 enable.
- read1_addr_i  input  5  read port 1 address.
- read2_en_i  input  1  read port 2 enable.
- read2_addr_i  input  5  read port 2 address.
- read1_data_o  output  32  read port 1 data, combinational.
- read2_data_o  output  32  read port 2 data, combinational.
- wb_en_o  output  1  MEM/WB latched write enable (pending commit).
- wb_addr_o  output  5  MEM/WB latched destination.
- wb_data_o  output  32  MEM/WB latched data.
- commit_cnt_o  output  32  count of committed register writes.

Function
REQ-003 SHALL contain a MEM/WB latch (wb_en_o, wb_addr_o, wb_data_o) and a 32x32 register file; register 0 is never written and always reads 0.
REQ-004 Latch update at each clk edge, priority order: rst low -> clear; else flush_i=1 -> wb_en_o=0, addr/data=0; else stall_i=1 -> hold; else load write_reg_*_i.
REQ-005 flush_i SHALL take priority over stall_i.
REQ-006 Commit: at a clk edge with rst high, stall_i=0, wb_en_o=1, wb_addr_o!=0 -> regs[wb_addr_o] <= wb_data_o.
REQ-007 Commit SHALL use the latch value before that edge's latch update; one edge latches, the next edge commits (latency 2 edges from MEM input to register file).
REQ-008 Commit SHALL occur even when flush_i=1 on the same edge (flush kills only the incoming entry).
REQ-009 While stalled, a pending write SHALL NOT commit; it commits exactly once, on the first edge with stall_i=0.
REQ-010 readN_data_o: readN_en_i=0 -> 0; addr=0 -> 0; else wb_en_o=1 and wb_addr_o==addr -> wb_data_o (bypass); else regs[addr].
REQ-011 Bypass SHALL apply regardless of stall_i; write_reg_*_i SHALL NOT be bypassed.
REQ-012 Both read ports SHALL be independent; identical addresses return identical data.
REQ-013 commit_cnt_o SHALL increment by 1 on every edge where REQ-006 commits, saturating at 32'hFFFFFFFF.

Reset
REQ-014 With rst=0 at an edge: wb_en_o=0, wb_addr_o=0, wb_data_o=0, commit_cnt_o=0, all registers 0; no commit that edge.
REQ-015 Reset mid-operation SHALL discard a pending latched write without committing it.
REQ-016 Read outputs SHALL reflect cleared state combinationally after the reset edge.

Verification
REQ-017 Basic: write en=1, addr=5, data=0xDEADBEEF for 1 cycle -> next edge wb_*_o=1/5/0xDEADBEEF, read1(5) bypasses 0xDEADBEEF; following edge regs[5]=0xDEADBEEF, commit_cnt_o=1.
REQ-018 Zero register: write addr=0, data=0x12345678 -> wb_en_o=1 but read(0)=0, no commit, commit_cnt_o unchanged.
REQ-019 Stall: latch addr=7/0x11 then stall_i=1 for 3 cycles -> regs[7] unchanged, read(7)=0x11 via bypass, commit_cnt_o unchanged; release -> commits once, commit_cnt_o +1.
REQ-020 Flush vs stall: latch addr=3/0xA5 pending, then flush_i=1 and stall_i=1 with new input addr=4/0x5A -> regs[3]=0xA5 not committed (stalled), wb_en_o=0, regs[4] never written.
REQ-021 Back-to-back same address: addr=9 data 0x1 then 0x2 on consecutive cycles -> read(9) yields 0x1 then 0x2 via bypass, final regs[9]=0x2, commit_cnt_o +2.
REQ-022 Reset mid-op: latch addr=10/0xFF, assert rst=0 next edge -> regs[10]=0, wb_en_o=0, commit_cnt_o=0.

Source files
------------

// File: rtl/wb_regfile.sv
// MEM/WB pipeline latch in front of a 32x32 register file, with two combinational
// read ports that bypass the pending write-back.

module wb_regfile_rdport #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                       en,
    input  logic [AW-1:0]              addr,
    input  logic                       wb_en,
    input  logic [AW-1:0]              wb_addr,
    input  logic [DW-1:0]              wb_data,
    input  logic [(1<<AW)-1:0][DW-1:0] regs,
    output logic [DW-1:0]              data
);
    // A pending write-back is newer than the array, so it wins on an address hit.
    always_comb begin
        data = '0;
        if (en && addr != '0) begin
            if (wb_en && wb_addr == addr)
                data = wb_data;
            else
                data = regs[addr];
        end
    end
endmodule

module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        write_reg_en_i,
    input  logic [4:0]  write_reg_addr_i,
    input  logic [31:0] write_reg_data_i,
    input  logic        read1_en_i,
    input  logic [4:0]  read1_addr_i,
    input  logic        read2_en_i,
    input  logic [4:0]  read2_addr_i,
    output logic [31:0] read1_data_o,
    output logic [31:0] read2_data_o,
    output logic        wb_en_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] commit_cnt_o
);
    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int NREG   = 1 << AW;
    localparam int NUM_RD = 2;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_ent_t;

    wb_ent_t                      wb_q;
    wb_ent_t                      wb_in;
    logic [NREG-1:0][DW-1:0]      regs;
    logic [DW-1:0]                cnt_q;
    logic                         commit;

    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][DW-1:0]    rd_data;

    assign wb_in = '{en: write_reg_en_i, addr: write_reg_addr_i, data: write_reg_data_i};

    // Commit sees the latch contents from before this edge; flush only kills the
    // incoming entry, so it does not block the commit.
    assign commit = !stall_i && wb_q.en && (wb_q.addr != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_q  <= '0;
            regs  <= '0;
            cnt_q <= '0;
        end else begin
            if (commit) begin
                regs[wb_q.addr] <= wb_q.data;
                if (cnt_q != '1)
                    cnt_q <= cnt_q + 1'b1;
            end
            if (flush_i)
                wb_q <= '0;
            else if (!stall_i)
                wb_q <= wb_in;
        end
    end

    assign rd_en   = {read2_en_i, read1_en_i};
    assign rd_addr = {read2_addr_i, read1_addr_i};

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            wb_regfile_rdport #(.DW(DW), .AW(AW)) u_rd (
                .en      (rd_en[p]),
                .addr    (rd_addr[p]),
                .wb_en   (wb_q.en),
                .wb_addr (wb_q.addr),
                .wb_data (wb_q.data),
                .regs    (regs),
                .data    (rd_data[p])
            );
        end
    endgenerate

    assign read1_data_o = rd_data[0];
    assign read2_data_o = rd_data[1];
    assign wb_en_o      = wb_q.en;
    assign wb_addr_o    = wb_q.addr;
    assign wb_data_o    = wb_q.data;
    assign commit_cnt_o = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector table plus random traffic for wb_regfile, checked against an
// array-based model of the write-back/commit rules.

module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i;
    logic        write_reg_en_i;
    logic [4:0]  write_reg_addr_i;
    logic [31:0] write_reg_data_i;
    logic        read1_en_i, read2_en_i;
    logic [4:0]  read1_addr_i, read2_addr_i;
    logic [31:0] read1_data_o, read2_data_o;
    logic        wb_en_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] commit_cnt_o;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .write_reg_en_i(write_reg_en_i), .write_reg_addr_i(write_reg_addr_i),
        .write_reg_data_i(write_reg_data_i),
        .read1_en_i(read1_en_i), .read1_addr_i(read1_addr_i),
        .read2_en_i(read2_en_i), .read2_addr_i(read2_addr_i),
        .read1_data_o(read1_data_o), .read2_data_o(read2_data_o),
        .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .commit_cnt_o(commit_cnt_o)
    );

    typedef struct {
        bit       rst_n, stall, flush, en;
        bit [4:0] addr;
        bit [31:0] data;
        bit       r1en; bit [4:0] r1a;
        bit       r2en; bit [4:0] r2a;
        bit [31:0] e_r1, e_r2;
        bit       e_wben;
        bit [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model: architectural registers, one pending write-back slot, commit counter.
    bit [31:0] m_regs [32];
    bit        m_pen;
    bit [4:0]  m_paddr;
    bit [31:0] m_pdata;
    bit [31:0] m_cnt;

    task automatic chk(input string name, input bit [31:0] act, input bit [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input bit en, input bit [4:0] a);
        if (!en || a == 0) return 32'h0;
        if (m_pen && m_paddr == a) return m_pdata;
        return m_regs[a];
    endfunction

    task automatic model_edge();
        if (!rst) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_pen = 0; m_paddr = 0; m_pdata = 0; m_cnt = 0;
        end else begin
            if (!stall_i && m_pen && m_paddr != 0) begin
                m_regs[m_paddr] = m_pdata;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end
            if (flush_i) begin
                m_pen = 0; m_paddr = 0; m_pdata = 0;
            end else if (!stall_i) begin
                m_pen = write_reg_en_i; m_paddr = write_reg_addr_i; m_pdata = write_reg_data_i;
            end
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".r1"},   read1_data_o, m_read(read1_en_i, read1_addr_i));
        chk({tag, ".r2"},   read2_data_o, m_read(read2_en_i, read2_addr_i));
        chk({tag, ".wben"}, {31'b0, wb_en_o}, {31'b0, m_pen});
        chk({tag, ".wbad"}, {27'b0, wb_addr_o}, {27'b0, m_paddr});
        chk({tag, ".wbd"},  wb_data_o, m_pdata);
        chk({tag, ".cnt"},  commit_cnt_o, m_cnt);
    endtask

    task automatic add(input bit rn, st, fl, en, input bit [4:0] a, input bit [31:0] d,
                       input bit r1en, input bit [4:0] r1a, input bit r2en, input bit [4:0] r2a,
                       input bit [31:0] er1, er2, input bit ewb, input bit [31:0] ecnt);
        vec_t v;
        v.rst_n = rn; v.stall = st; v.flush = fl; v.en = en; v.addr = a; v.data = d;
        v.r1en = r1en; v.r1a = r1a; v.r2en = r2en; v.r2a = r2a;
        v.e_r1 = er1; v.e_r2 = er2; v.e_wben = ewb; v.e_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit rn, st, fl, en, input bit [4:0] a, input bit [31:0] d,
                         input bit r1en, input bit [4:0] r1a, input bit r2en, input bit [4:0] r2a);
        rst = rn; stall_i = st; flush_i = fl;
        write_reg_en_i = en; write_reg_addr_i = a; write_reg_data_i = d;
        read1_en_i = r1en; read1_addr_i = r1a; read2_en_i = r2en; read2_addr_i = r2a;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Each row: inputs held across one edge, expected outputs just after it.
        //   rst st fl en addr data           r1    r2       exp r1        exp r2        wben cnt
        add(0, 0, 0, 0, 5'd0,  32'h0,        1,5'd5, 1,5'd5, 32'h0,        32'h0,        0, 0); // reset
        add(1, 0, 0, 1, 5'd5,  32'hDEADBEEF, 1,5'd5, 0,5'd5, 32'hDEADBEEF, 32'h0,        1, 0); // latch, bypass
        add(1, 0, 0, 0, 5'd0,  32'h0,        1,5'd5, 1,5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1); // commit
        add(1, 0, 0, 1, 5'd0,  32'h12345678, 1,5'd0, 1,5'd0, 32'h0,        32'h0,        1, 1); // r0 write
        add(1, 0, 0, 0, 5'd0,  32'h0,        1,5'd0, 1,5'd5, 32'h0,        32'hDEADBEEF, 0, 1); // no commit
        add(1, 0, 0, 1, 5'd7,  32'h11,       1,5'd7, 1,5'd8, 32'h11,       32'h0,        1, 1);
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 1, 5'd8, 32'h99,    1,5'd7, 1,5'd8, 32'h11,       32'h0,        1, 1); // stalled
        add(1, 0, 0, 0, 5'd0,  32'h0,        1,5'd7, 1,5'd8, 32'h11,       32'h0,        0, 2); // release
        add(1, 0, 0, 0, 5'd0,  32'h0,        1,5'd7, 1,5'd7, 32'h11,       32'h11,       0, 2); // once only
        add(1, 0, 0, 1, 5'd3,  32'hA5,       1,5'd3, 1,5'd4, 32'hA5,       32'h0,        1, 2);
        add(1, 1, 1, 1, 5'd4,  32'h5A,       1,5'd3, 1,5'd4, 32'h0,        32'h0,        0, 2); // flush+stall
        add(1, 0, 0, 0, 5'd0,  32'h0,        1,5'd3, 1,5'd4, 32'h0,        32'h0,        0, 2);
        add(1, 0, 0, 1, 5'd9,  32'h1,        1,5'd9, 1,5'd9, 32'h1,        32'h1,        1, 2); // b2b
        add(1, 0, 0, 1, 5'd9,  32'h2,        1,5'd9, 1,5'd9, 32'h2,        32'h2,        1, 3);
        add(1, 0, 0, 0, 5'd0,  32'h0,        1,5'd9, 0,5'd9, 32'h2,        32'h0,        0, 4);
        add(1, 0, 0, 1, 5'd12, 32'hC,        1,5'd12,1,5'd13,32'hC,        32'h0,        1, 4);
        add(1, 0, 1, 1, 5'd13, 32'hD,        1,5'd12,1,5'd13,32'hC,        32'h0,        0, 5); // flush commits
        add(1, 0, 0, 1, 5'd10, 32'hFF,       1,5'd10,1,5'd9, 32'hFF,       32'h2,        1, 5);
        add(0, 0, 0, 1, 5'd11, 32'h77,       1,5'd10,1,5'd9, 32'h0,        32'h0,        0, 0); // reset mid-op
        add(1, 0, 0, 0, 5'd0,  32'h0,        1,5'd10,1,5'd5, 32'h0,        32'h0,        0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            string tag;
            v = vecs[i];
            drive(v.rst_n, v.stall, v.flush, v.en, v.addr, v.data, v.r1en, v.r1a, v.r2en, v.r2a);
            @(posedge clk);
            model_edge();
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, ".r1"},   read1_data_o, v.e_r1);
            chk({tag, ".r2"},   read2_data_o, v.e_r2);
            chk({tag, ".wben"}, {31'b0, wb_en_o}, {31'b0, v.e_wben});
            chk({tag, ".cnt"},  commit_cnt_o, v.e_cnt);
        end

        // Random traffic over a narrow address range so bypass hits and r0 are common.
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)));
            @(posedge clk);
            model_edge();
            #1;
            chk_model($sformatf("rnd%0d", c));
            // Re-point the read ports mid-cycle: outputs must follow combinationally.
            read1_en_i = 1; read1_addr_i = 5'($urandom_range(0, 7));
            read2_en_i = 1; read2_addr_i = read1_addr_i;
            #1;
            chk($sformatf("rnd%0d.c1", c), read1_data_o, m_read(1, read1_addr_i));
            chk($sformatf("rnd%0d.c2", c), read2_data_o, read1_data_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
